// File: rtl/cpu_pkg.sv
// Shared RV32I front-end types: opcodes, ALU operations, immediate selects
// and the control bundle carried from decode into execute.
// No ports; imported by decode_stage_if, imm_gen and decode_stage.
package cpu_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned WB_SEL_W = 2;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  // Write-back source select
  localparam logic [WB_SEL_W-1:0] WB_ALU = 2'd0;
  localparam logic [WB_SEL_W-1:0] WB_MEM = 2'd1;
  localparam logic [WB_SEL_W-1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    alu_op_e             alu_op;
    logic                alu_src_imm;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                branch;
    logic                jump;
    logic [WB_SEL_W-1:0] wb_sel;
  } ctrl_t;

  // funct3 to ALU op; alt selects SUB/SRA (instr[30]) where the caller allows it
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus between fetch / register file / EX and the decode stage.
// slave  : decode side (takes i_*, drives o_*).
// master : environment side (drives i_*, takes o_*).
// Signals: fetch handshake (i_if_valid/o_if_ready, i_instr, i_pc), register
// file read ports (o_rs*_addr, i_rs*_data), write-back bypass (i_wb_*),
// i_flush from EX, and the registered ID/EX payload with o_ex_valid/i_ex_ready.
interface decode_stage_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
);
  import cpu_pkg::*;

  localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

  logic                  i_if_valid;
  logic                  o_if_ready;
  logic [INSTR_W-1:0]    i_instr;
  logic [XLEN-1:0]       i_pc;
  logic [REG_ADDR_W-1:0] o_rs1_addr;
  logic [REG_ADDR_W-1:0] o_rs2_addr;
  logic [XLEN-1:0]       i_rs1_data;
  logic [XLEN-1:0]       i_rs2_data;
  logic                  i_wb_en;
  logic [REG_ADDR_W-1:0] i_wb_addr;
  logic [XLEN-1:0]       i_wb_data;
  logic                  i_flush;
  logic                  o_ex_valid;
  logic                  i_ex_ready;
  logic [XLEN-1:0]       o_pc;
  logic [XLEN-1:0]       o_rs1_data;
  logic [XLEN-1:0]       o_rs2_data;
  logic [XLEN-1:0]       o_imm;
  logic [REG_ADDR_W-1:0] o_rs1;
  logic [REG_ADDR_W-1:0] o_rs2;
  logic [REG_ADDR_W-1:0] o_rd;
  ctrl_t                 o_ctrl;
  logic                  o_illegal;

  modport slave (
    input  i_if_valid, i_instr, i_pc, i_rs1_data, i_rs2_data,
           i_wb_en, i_wb_addr, i_wb_data, i_flush, i_ex_ready,
    output o_if_ready, o_rs1_addr, o_rs2_addr, o_ex_valid, o_pc,
           o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd, o_ctrl, o_illegal
  );

  modport master (
    output i_if_valid, i_instr, i_pc, i_rs1_data, i_rs2_data,
           i_wb_en, i_wb_addr, i_wb_data, i_flush, i_ex_ready,
    input  o_if_ready, o_rs1_addr, o_rs2_addr, o_ex_valid, o_pc,
           o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd, o_ctrl, o_illegal
  );

endinterface

// File: rtl/imm_gen.sv
// RV32I immediate generator: selects the I/S/B/U/J field layout and
// sign-extends from instr[31] to XLEN. Purely combinational.
// Ports: i_instr (instruction word), i_imm_sel (format), o_imm_c (immediate).
module imm_gen
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] i_instr,
  input  imm_sel_e           i_imm_sel,
  output logic [XLEN-1:0]    o_imm_c
);

  logic [31:0] w_imm32;
  logic        w_unused_opcode;

  // Field layouts for each format
  always_comb begin
    w_imm32 = '0;
    case (i_imm_sel)
      IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign o_imm_c = XLEN'($signed(w_imm32));

  // Opcode bits carry no immediate information
  assign w_unused_opcode = ^i_instr[6:0];

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage with ID/EX pipeline register.
// Accepts instructions from fetch (valid/ready), drives register-file read
// addresses combinationally, and captures operands, immediate, register
// indices and the control bundle into ID/EX. Stalls one bubble on a load-use
// hazard against its own ID/EX entry and drops the ID instruction on i_flush.
// Ports: i_clk, i_reset (async, active-high), bus (decode_stage_if.slave).
// Option: define DECODE_WB_BYPASS_EN to forward i_wb_data onto matching
// operands (register file writing on the rising edge); otherwise the
// write-back port is ignored.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic           i_clk,
  input  logic           i_reset,
  decode_stage_if.slave  bus
);

  localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

  logic [OPCODE_W-1:0]   w_opcode;
  logic [2:0]            w_funct3;
  logic [REG_ADDR_W-1:0] w_rs1_addr;
  logic [REG_ADDR_W-1:0] w_rs2_addr;
  logic [REG_ADDR_W-1:0] w_rd_addr;
  ctrl_t                 w_ctrl;
  imm_sel_e              w_imm_sel;
  logic                  w_illegal;
  logic                  w_rs1_used;
  logic                  w_rs2_used;
  logic [XLEN-1:0]       w_imm;
  logic [XLEN-1:0]       w_rs1_data;
  logic [XLEN-1:0]       w_rs2_data;
  logic                  w_adv;
  logic                  w_luse;

  logic                  r_ex_valid;
  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [XLEN-1:0]       r_imm;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  ctrl_t                 r_ctrl;
  logic                  r_illegal;

  assign w_opcode   = bus.i_instr[6:0];
  assign w_funct3   = bus.i_instr[14:12];
  assign w_rs1_addr = REG_ADDR_W'(bus.i_instr[19:15]);
  assign w_rs2_addr = REG_ADDR_W'(bus.i_instr[24:20]);
  assign w_rd_addr  = REG_ADDR_W'(bus.i_instr[11:7]);

  // Opcode decode: control bundle, immediate format and source usage
  always_comb begin
    w_ctrl     = '0;
    w_imm_sel  = IMM_I;
    w_illegal  = 1'b0;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        w_ctrl.alu_op      = ALU_PASS_B;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_imm_sel          = IMM_U;
      end
      OP_AUIPC: begin
        w_ctrl.alu_op      = ALU_ADD;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_imm_sel          = IMM_U;
      end
      OP_JAL: begin
        w_ctrl.alu_op      = ALU_ADD;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.jump        = 1'b1;
        w_ctrl.wb_sel      = WB_PC4;
        w_imm_sel          = IMM_J;
      end
      OP_JALR: begin
        w_ctrl.alu_op      = ALU_ADD;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.jump        = 1'b1;
        w_ctrl.wb_sel      = WB_PC4;
        w_imm_sel          = IMM_I;
        w_rs1_used         = 1'b1;
      end
      OP_BRANCH: begin
        w_ctrl.alu_op      = ALU_SUB;
        w_ctrl.branch      = 1'b1;
        w_imm_sel          = IMM_B;
        w_rs1_used         = 1'b1;
        w_rs2_used         = 1'b1;
      end
      OP_LOAD: begin
        w_ctrl.alu_op      = ALU_ADD;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.mem_read    = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.wb_sel      = WB_MEM;
        w_imm_sel          = IMM_I;
        w_rs1_used         = 1'b1;
      end
      OP_STORE: begin
        w_ctrl.alu_op      = ALU_ADD;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.mem_write   = 1'b1;
        w_imm_sel          = IMM_S;
        w_rs1_used         = 1'b1;
        w_rs2_used         = 1'b1;
      end
      OP_IMM: begin
        // instr[30] is immediate data except for SRAI
        w_ctrl.alu_op      = alu_decode(w_funct3,
                                        bus.i_instr[30] & (w_funct3 == 3'b101));
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_imm_sel          = IMM_I;
        w_rs1_used         = 1'b1;
      end
      OP_REG: begin
        w_ctrl.alu_op      = alu_decode(w_funct3, bus.i_instr[30]);
        w_ctrl.reg_write   = 1'b1;
        w_rs1_used         = 1'b1;
        w_rs2_used         = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
    // x0 is never written
    if (w_rd_addr == '0) begin
      w_ctrl.reg_write = 1'b0;
    end
  end

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .i_instr   (bus.i_instr),
    .i_imm_sel (w_imm_sel),
    .o_imm_c   (w_imm)
  );

  // Operand source: optional forwarding of the same-cycle write-back
`ifdef DECODE_WB_BYPASS_EN
  assign w_rs1_data = (bus.i_wb_en && (bus.i_wb_addr != '0) && (bus.i_wb_addr == w_rs1_addr))
                      ? bus.i_wb_data : bus.i_rs1_data;
  assign w_rs2_data = (bus.i_wb_en && (bus.i_wb_addr != '0) && (bus.i_wb_addr == w_rs2_addr))
                      ? bus.i_wb_data : bus.i_rs2_data;
`else
  logic w_unused_wb;
  assign w_rs1_data  = bus.i_rs1_data;
  assign w_rs2_data  = bus.i_rs2_data;
  assign w_unused_wb = ^{bus.i_wb_en, bus.i_wb_addr, bus.i_wb_data};
`endif

  // Handshake and load-use hazard against the load currently in ID/EX
  assign w_adv  = !r_ex_valid || bus.i_ex_ready;
  assign w_luse = r_ex_valid && r_ctrl.mem_read && (r_rd != '0) &&
                  ((w_rs1_used && (r_rd == w_rs1_addr)) ||
                   (w_rs2_used && (r_rd == w_rs2_addr)));

  // ID/EX register: flush > bubble > load > drain > hold
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ex_valid <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= '0;
      r_illegal  <= 1'b0;
    end else if (bus.i_flush || (w_adv && (w_luse || !bus.i_if_valid))) begin
      r_ex_valid <= 1'b0;
      r_ctrl     <= '0;
      r_illegal  <= 1'b0;
    end else if (w_adv) begin
      r_ex_valid <= 1'b1;
      r_pc       <= bus.i_pc;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_rs1      <= w_rs1_addr;
      r_rs2      <= w_rs2_addr;
      r_rd       <= w_rd_addr;
      r_ctrl     <= w_ctrl;
      r_illegal  <= w_illegal;
    end
  end

  assign bus.o_if_ready = w_adv && !w_luse && !bus.i_flush;
  assign bus.o_rs1_addr = w_rs1_addr;
  assign bus.o_rs2_addr = w_rs2_addr;
  assign bus.o_ex_valid = r_ex_valid;
  assign bus.o_pc       = r_pc;
  assign bus.o_rs1_data = r_rs1_data;
  assign bus.o_rs2_data = r_rs2_data;
  assign bus.o_imm      = r_imm;
  assign bus.o_rs1      = r_rs1;
  assign bus.o_rs2      = r_rs2;
  assign bus.o_rd       = r_rd;
  assign bus.o_ctrl     = r_ctrl;
  assign bus.o_illegal  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: table of decoded instructions checked through
// an accept/retire scoreboard, plus hand sequences for load-use stall,
// EX back-pressure, flush, write-back bypass and reset during a stall.
module tb_decode_stage;
  import cpu_pkg::*;

  logic clk;
  logic rst;

  decode_stage_if #(.XLEN(32), .NUM_REGS(32)) bus ();

  decode_stage #(.XLEN(32), .NUM_REGS(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic        chk_imm;
    logic [31:0] imm;
    ctrl_t       ctrl;
    logic        illegal;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic        chk_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    ctrl_t       ctrl;
    logic        illegal;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sbq[$];
  exp_t cur_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic ctrl_t cv(input alu_op_e op, input logic src, input logic mr,
                               input logic mw, input logic rw, input logic br,
                               input logic jp, input logic [1:0] wb);
    ctrl_t c;
    c.alu_op = op; c.alu_src_imm = src; c.mem_read = mr; c.mem_write = mw;
    c.reg_write = rw; c.branch = br; c.jump = jp; c.wb_sel = wb;
    return c;
  endfunction

  function automatic vec_t mkv(input string nm, input logic [31:0] instr, input logic [31:0] pc,
                               input logic ci, input logic [31:0] imm, input ctrl_t c,
                               input logic ill);
    vec_t v;
    v.name = nm; v.instr = instr; v.pc = pc;
    v.rs1d = 32'h1000_0000 | pc; v.rs2d = 32'h2000_0000 | pc;
    v.chk_imm = ci; v.imm = imm; v.ctrl = c; v.illegal = ill;
    return v;
  endfunction

  function automatic exp_t mke(input vec_t v, input logic [31:0] rs1d);
    exp_t e;
    logic [31:0] ins;
    ins = v.instr;
    e.name = v.name; e.pc = v.pc; e.rs1d = rs1d; e.rs2d = v.rs2d;
    e.chk_imm = v.chk_imm; e.imm = v.imm;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.ctrl = v.ctrl; e.illegal = v.illegal;
    return e;
  endfunction

  // Scoreboard: retire on EX transfer, then record a new accept
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.o_ex_valid && bus.i_ex_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_ex_valid", 32'(bus.o_ex_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_pc"},      bus.o_pc, e.pc);
          chk({e.name, "_rs1data"}, bus.o_rs1_data, e.rs1d);
          chk({e.name, "_rs2data"}, bus.o_rs2_data, e.rs2d);
          chk({e.name, "_rs1"},     32'(bus.o_rs1), 32'(e.rs1));
          chk({e.name, "_rs2"},     32'(bus.o_rs2), 32'(e.rs2));
          chk({e.name, "_rd"},      32'(bus.o_rd), 32'(e.rd));
          chk({e.name, "_ctrl"},    32'(bus.o_ctrl), 32'(e.ctrl));
          chk({e.name, "_illegal"}, 32'(bus.o_illegal), 32'(e.illegal));
          if (e.chk_imm) chk({e.name, "_imm"}, bus.o_imm, e.imm);
        end
      end
      if (bus.i_if_valid && bus.o_if_ready) sbq.push_back(cur_exp);
    end
  end

  task automatic present(input vec_t v, input logic [31:0] exp_rs1d);
    bus.i_instr    = v.instr;
    bus.i_pc       = v.pc;
    bus.i_rs1_data = v.rs1d;
    bus.i_rs2_data = v.rs2d;
    cur_exp        = mke(v, exp_rs1d);
    bus.i_if_valid = 1'b1;
  endtask

  // Present one instruction until accepted (bounded); returns stall cycles
  task automatic send(input vec_t v, input logic [31:0] exp_rs1d, output int stalls);
    bit acc;
    acc = 0;
    stalls = 0;
    present(v, exp_rs1d);
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (bus.o_if_ready) acc = 1; else stalls++;
      @(posedge clk); #1;
    end
    bus.i_if_valid = 1'b0;
    if (!acc) chk({v.name, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  vec_t tbl[12];
  vec_t v_lw, v_add_h, v_add, v_addi;
  int   st;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mkv("addi",  32'h00500093, 32'h100, 1, 32'h0000_0005, cv(ALU_ADD,    1,0,0,1,0,0,WB_ALU), 0);
    tbl[1]  = mkv("beq",   32'hFE000EE3, 32'h104, 1, 32'hFFFF_FFFC, cv(ALU_SUB,    0,0,0,0,1,0,WB_ALU), 0);
    tbl[2]  = mkv("lui",   32'h123452B7, 32'h108, 1, 32'h1234_5000, cv(ALU_PASS_B, 1,0,0,1,0,0,WB_ALU), 0);
    tbl[3]  = mkv("sw",    32'hFE20AE23, 32'h10C, 1, 32'hFFFF_FFFC, cv(ALU_ADD,    1,0,1,0,0,0,WB_ALU), 0);
    tbl[4]  = mkv("jal",   32'h008000EF, 32'h110, 1, 32'h0000_0008, cv(ALU_ADD,    1,0,0,1,0,1,WB_PC4), 0);
    tbl[5]  = mkv("jalr",  32'h000280E7, 32'h114, 1, 32'h0000_0000, cv(ALU_ADD,    1,0,0,1,0,1,WB_PC4), 0);
    tbl[6]  = mkv("sub",   32'h402081B3, 32'h118, 0, 32'h0,         cv(ALU_SUB,    0,0,0,1,0,0,WB_ALU), 0);
    tbl[7]  = mkv("auipc", 32'hFFFFF217, 32'h11C, 1, 32'hFFFF_F000, cv(ALU_ADD,    1,0,0,1,0,0,WB_ALU), 0);
    tbl[8]  = mkv("srai",  32'h4032D293, 32'h120, 1, 32'h0000_0403, cv(ALU_SRA,    1,0,0,1,0,0,WB_ALU), 0);
    tbl[9]  = mkv("blt",   32'h0020C863, 32'h124, 1, 32'h0000_0010, cv(ALU_SUB,    0,0,0,0,1,0,WB_ALU), 0);
    tbl[10] = mkv("nop",   32'h00000013, 32'h128, 1, 32'h0000_0000, cv(ALU_ADD,    1,0,0,0,0,0,WB_ALU), 0);
    tbl[11] = mkv("fence", 32'h0000000F, 32'h12C, 0, 32'h0,         '0,                                  1);

    v_lw    = mkv("lw",    32'h0000A103, 32'h200, 1, 32'h0, cv(ALU_ADD, 1,1,0,1,0,0,WB_MEM), 0);
    v_add_h = mkv("add_h", 32'h001101B3, 32'h204, 0, 32'h0, cv(ALU_ADD, 0,0,0,1,0,0,WB_ALU), 0);
    v_add   = mkv("add",   32'h002081B3, 32'h300, 0, 32'h0, cv(ALU_ADD, 0,0,0,1,0,0,WB_ALU), 0);
    v_addi  = mkv("addi2", 32'h00500093, 32'h304, 1, 32'h5, cv(ALU_ADD, 1,0,0,1,0,0,WB_ALU), 0);

    rst = 1'b1;
    bus.i_if_valid = 0; bus.i_instr = 32'h00500093; bus.i_pc = '0;
    bus.i_rs1_data = '0; bus.i_rs2_data = '0; bus.i_wb_en = 0; bus.i_wb_addr = '0;
    bus.i_wb_data = '0; bus.i_flush = 0; bus.i_ex_ready = 1;
    cur_exp = mke(tbl[0], 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(bus.o_ex_valid), 32'd0);
    chk("rst_ctrl",     32'(bus.o_ctrl), 32'd0);
    chk("rst_illegal",  32'(bus.o_illegal), 32'd0);
    chk("rst_pc",       bus.o_pc, 32'd0);
    chk("rst_imm",      bus.o_imm, 32'd0);
    chk("rst_rd",       32'(bus.o_rd), 32'd0);
    chk("rs1_addr_comb", 32'(bus.o_rs1_addr), 32'd0);
    chk("rs2_addr_comb", 32'(bus.o_rs2_addr), 32'd5);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: back-to-back, no hazards, EX always ready
    foreach (tbl[i]) begin
      send(tbl[i], tbl[i].rs1d, st);
      chk({tbl[i].name, "_stalls"}, 32'(st), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;

    // Load-use: lw x2 then add x3,x2,x1 -> one stall cycle, one bubble
    send(v_lw, v_lw.rs1d, st);
    present(v_add_h, v_add_h.rs1d);
    @(negedge clk);
    chk("luse_ready_low", 32'(bus.o_if_ready), 32'd0);
    chk("luse_lw_in_ex",  32'(bus.o_rd), 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bubble_valid", 32'(bus.o_ex_valid), 32'd0);
    chk("bubble_ctrl",  32'(bus.o_ctrl), 32'd0);
    chk("bubble_ready", 32'(bus.o_if_ready), 32'd1);
    @(posedge clk); #1;
    bus.i_if_valid = 0;
    @(negedge clk);
    chk("luse_add_valid", 32'(bus.o_ex_valid), 32'd1);
    chk("luse_add_rs1",   32'(bus.o_rs1), 32'd2);
    chk("luse_add_rs2",   32'(bus.o_rs2), 32'd1);
    @(posedge clk); #1;

    // EX back-pressure: add held for 3 cycles, then addi loads
    send(v_add, v_add.rs1d, st);
    bus.i_ex_ready = 0;
    present(v_addi, v_addi.rs1d);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.o_ex_valid), 32'd1);
      chk("hold_pc",    bus.o_pc, 32'h300);
      chk("hold_rd",    32'(bus.o_rd), 32'd3);
      chk("hold_rs1d",  bus.o_rs1_data, 32'h1000_0300);
      chk("hold_ready", 32'(bus.o_if_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.i_ex_ready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.i_if_valid = 0;
    @(negedge clk);
    chk("after_hold_pc", bus.o_pc, 32'h304);
    chk("after_hold_rd", 32'(bus.o_rd), 32'd1);
    @(posedge clk); #1;

    // Flush with valid instruction and pending load-use stall
    send(v_lw, v_lw.rs1d, st);
    present(v_add_h, v_add_h.rs1d);
    bus.i_flush = 1;
    @(negedge clk);
    chk("flush_ready", 32'(bus.o_if_ready), 32'd0);
    @(posedge clk); #1;
    bus.i_flush = 0;
    bus.i_if_valid = 0;
    @(negedge clk);
    chk("flush_valid", 32'(bus.o_ex_valid), 32'd0);
    chk("flush_ctrl",  32'(bus.o_ctrl), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_not_captured", 32'(bus.o_ex_valid), 32'd0);
    @(posedge clk); #1;

    // Write-back bypass on operand A
    bus.i_wb_en = 1; bus.i_wb_addr = 5'd1; bus.i_wb_data = 32'h0000_DEAD;
`ifdef DECODE_WB_BYPASS_EN
    send(v_add, 32'h0000_DEAD, st);
`else
    send(v_add, v_add.rs1d, st);
`endif
    bus.i_wb_addr = 5'd0;
    send(v_add, v_add.rs1d, st);
    bus.i_wb_en = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during a load-use stall leaves the pipeline empty
    send(v_lw, v_lw.rs1d, st);
    present(v_add_h, v_add_h.rs1d);
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    chk("rst_stall_valid", 32'(bus.o_ex_valid), 32'd0);
    chk("rst_stall_ctrl",  32'(bus.o_ctrl), 32'd0);
    @(posedge clk); #1;
    bus.i_if_valid = 0;
    rst = 0;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.o_ex_valid), 32'd0);
    chk("post_rst_ready", 32'(bus.o_if_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
